// File: rtl/wave_generator.sv
// wave_generator: programmable waveform source producing triangle,
// sawtooth-up, sawtooth-down or square waves between runtime bounds lo..hi.
// State advances only on cycles with ena high. evt pulses for exactly one
// cycle, together with the out value produced by a turnaround, wrap or toggle.
module wave_generator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [1:0]   mode,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] step,
  output logic [N-1:0] out,
  output logic         dir,
  output logic         evt
);

  typedef enum logic [1:0] {
    MODE_TRI     = 2'd0,
    MODE_SAW_UP  = 2'd1,
    MODE_SAW_DN  = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_e;

  // Architectural state and its next-state values.
  logic [N-1:0] out_q, out_d;
  logic         dir_q, dir_d;
  logic         evt_q, evt_d;
  logic [N-1:0] cnt_q, cnt_d;
  mode_e        mode_q, mode_d;

  // Ramp arithmetic. Sums and differences are formed one bit wider than the
  // sample so that overflow/underflow is visible, then clamped to the bounds.
  logic [N-1:0] step_eff;
  logic [N:0]   up_sum;
  logic [N:0]   dn_diff;
  logic [N-1:0] up_val;
  logic [N-1:0] dn_val;
  logic         bounds_bad;
  logic         out_outside;
  logic         at_hi;
  logic         at_lo;

  // A zero ramp step would freeze the ramp, so it counts as a step of one.
  assign step_eff    = (step == '0) ? {{(N-1){1'b0}}, 1'b1} : step;
  assign up_sum      = {1'b0, out_q} + {1'b0, step_eff};
  assign dn_diff     = {1'b0, out_q} - {1'b0, step_eff};
  assign up_val      = (up_sum > {1'b0, hi}) ? hi : up_sum[N-1:0];
  assign dn_val      = (dn_diff[N] || (dn_diff[N-1:0] < lo)) ? lo : dn_diff[N-1:0];
  assign bounds_bad  = (lo > hi);
  assign out_outside = (out_q < lo) || (out_q > hi);
  assign at_hi       = (out_q >= hi);
  assign at_lo       = (out_q <= lo);

  // Next-state selection: invalid bounds, then mode restart, then clamping of
  // an out-of-range ramp, then the per-mode waveform update.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    evt_d  = 1'b0;
    if (ena) begin
      if (bounds_bad) begin
        // Park at lo until the bounds become consistent again.
        out_d = lo;
        dir_d = 1'b0;
        cnt_d = '0;
      end else if (mode != mode_q) begin
        // Any mode change restarts the waveform from lo in the rising phase.
        mode_d = mode_e'(mode);
        out_d  = lo;
        dir_d  = 1'b0;
        cnt_d  = '0;
      end else if ((mode != MODE_SQUARE) && out_outside) begin
        // Bounds were reprogrammed under a ramp: pull it back in silently.
        out_d = (out_q < lo) ? lo : hi;
      end else begin
        unique case (mode_q)
          MODE_TRI: begin
            if (!dir_q) begin
              if (at_hi) begin
                dir_d = 1'b1;
                out_d = dn_val;
                evt_d = 1'b1;
              end else begin
                out_d = up_val;
              end
            end else begin
              if (at_lo) begin
                dir_d = 1'b0;
                out_d = up_val;
                evt_d = 1'b1;
              end else begin
                out_d = dn_val;
              end
            end
          end
          MODE_SAW_UP: begin
            dir_d = 1'b0;
            if (at_hi) begin
              out_d = lo;
              evt_d = 1'b1;
            end else begin
              out_d = up_val;
            end
          end
          MODE_SAW_DN: begin
            dir_d = 1'b1;
            if (at_lo) begin
              out_d = hi;
              evt_d = 1'b1;
            end else begin
              out_d = dn_val;
            end
          end
          MODE_SQUARE: begin
            // cnt counts enabled cycles within the current half-period; the
            // raw step (zero included) is the terminal count.
            if (cnt_q == step) begin
              cnt_d = '0;
              dir_d = ~dir_q;
              out_d = dir_q ? hi : lo;
              evt_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
              out_d = dir_q ? lo : hi;
            end
          end
          default: begin
            out_d = out_q;
          end
        endcase
      end
    end
  end

  // State register; reset overrides everything, including an enabled update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= 1'b0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_TRI;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign out = out_q;
  assign dir = dir_q;
  assign evt = evt_q;

endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: directed scenarios with literal expected sequences, then
// randomized stimulus compared every cycle against an integer reference model.
`timescale 1ns/1ps
module tb_wave_generator;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [1:0]   mode;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] step;
  logic [N-1:0] out;
  logic         dir;
  logic         evt;

  int n_pass  = 0;
  int n_total = 0;

  wave_generator #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .mode (mode),
    .lo   (lo),
    .hi   (hi),
    .step (step),
    .out  (out),
    .dir  (dir),
    .evt  (evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  // Reference model: plain integers, rules applied directly.
  int  m_out, m_dir, m_cnt, m_mode, m_evt;
  bit  m_valid = 1'b0;
  int  r_lo, r_hi, r_st, r_s, r_md;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_out = 0; m_dir = 0; m_cnt = 0; m_mode = 0; m_evt = 0;
      m_valid = 1'b1;
    end else if (!ena) begin
      m_evt = 0;
    end else begin
      r_lo = int'(lo); r_hi = int'(hi); r_st = int'(step); r_md = int'(mode);
      r_s  = (r_st == 0) ? 1 : r_st;
      m_evt = 0;
      if (r_lo > r_hi) begin
        m_out = r_lo; m_dir = 0; m_cnt = 0;
      end else if (r_md != m_mode) begin
        m_mode = r_md; m_out = r_lo; m_dir = 0; m_cnt = 0;
      end else if (r_md != 3 && (m_out < r_lo || m_out > r_hi)) begin
        m_out = (m_out < r_lo) ? r_lo : r_hi;
      end else if (r_md == 0) begin
        if (m_dir == 0 && m_out >= r_hi) begin
          m_dir = 1; m_out = imax(m_out - r_s, r_lo); m_evt = 1;
        end else if (m_dir == 0) begin
          m_out = imin(m_out + r_s, r_hi);
        end else if (m_out <= r_lo) begin
          m_dir = 0; m_out = imin(m_out + r_s, r_hi); m_evt = 1;
        end else begin
          m_out = imax(m_out - r_s, r_lo);
        end
      end else if (r_md == 1) begin
        m_dir = 0;
        if (m_out >= r_hi) begin m_out = r_lo; m_evt = 1; end
        else m_out = imin(m_out + r_s, r_hi);
      end else if (r_md == 2) begin
        m_dir = 1;
        if (m_out <= r_lo) begin m_out = r_hi; m_evt = 1; end
        else m_out = imax(m_out - r_s, r_lo);
      end else begin
        // Square: half-period of step+1 enabled cycles; the counter is N bits.
        if (m_cnt == r_st) begin
          m_cnt = 0; m_dir = 1 - m_dir; m_evt = 1;
          m_out = (m_dir == 1) ? r_lo : r_hi;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << N);
          m_out = (m_dir == 1) ? r_lo : r_hi;
        end
      end
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out", int'(out), m_out);
      chk("model_dir", int'(dir), m_dir);
      chk("model_evt", int'(evt), m_evt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and check DUT and model against hand-computed values.
  task automatic step_exp(input string nm, input int o, input int d, input int e);
    tick();
    chk({nm, "_out"}, int'(out), o);
    chk({nm, "_dir"}, int'(dir), d);
    chk({nm, "_evt"}, int'(evt), e);
    chk({nm, "_model"}, m_out, o);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; mode = 2'd0; lo = 8'd0; hi = 8'd255; step = 8'd1;
    tick();
    chk("reset_out", int'(out), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_evt", int'(evt), 0);
    rst = 1'b0; ena = 1'b1;

    // Full-range triangle, step 1.
    for (int i = 1; i <= 255; i++) begin
      tick();
      chk("tri_up", int'(out), i);
    end
    step_exp("tri_peak", 254, 1, 1);
    for (int i = 253; i >= 0; i--) begin
      tick();
      chk("tri_dn", int'(out), i);
      chk("tri_dn_dir", int'(dir), 1);
    end
    step_exp("tri_trough", 1, 0, 1);

    // Narrow triangle with a coarse step; first cycle clamps 1 up to 10.
    lo = 8'd10; hi = 8'd20; step = 8'd7;
    step_exp("tri2_clamp", 10, 0, 0);
    step_exp("tri2_a", 17, 0, 0);
    step_exp("tri2_b", 20, 0, 0);
    step_exp("tri2_c", 13, 1, 1);
    step_exp("tri2_d", 10, 1, 0);
    step_exp("tri2_e", 17, 0, 1);

    // Saw-up after reset, then saw-down.
    rst = 1'b1; mode = 2'd1; lo = 8'd5; hi = 8'd8; step = 8'd2;
    step_exp("rst2", 0, 0, 0);
    rst = 1'b0;
    step_exp("sawu_restart", 5, 0, 0);
    step_exp("sawu_a", 7, 0, 0);
    step_exp("sawu_b", 8, 0, 0);
    step_exp("sawu_wrap", 5, 0, 1);
    step_exp("sawu_c", 7, 0, 0);
    mode = 2'd2;
    step_exp("sawd_restart", 5, 0, 0);
    step_exp("sawd_wrap", 8, 1, 1);
    step_exp("sawd_a", 6, 1, 0);
    step_exp("sawd_b", 5, 1, 0);
    step_exp("sawd_wrap2", 8, 1, 1);

    // Square with half-period of 3 enabled cycles.
    mode = 2'd3; lo = 8'h10; hi = 8'hF0; step = 8'd2;
    step_exp("sq_restart", 16, 0, 0);
    step_exp("sq_a", 240, 0, 0);
    step_exp("sq_b", 240, 0, 0);
    step_exp("sq_tog1", 16, 1, 1);
    step_exp("sq_c", 16, 1, 0);
    step_exp("sq_d", 16, 1, 0);
    step_exp("sq_tog2", 240, 0, 1);

    // Triangle descending through 100, hold with ena low, then reset.
    mode = 2'd0; lo = 8'd0; hi = 8'd120; step = 8'd10;
    step_exp("tri3_restart", 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("tri3_up", int'(out), 10 * i);
    end
    step_exp("tri3_peak", 110, 1, 1);
    step_exp("tri3_dn", 100, 1, 0);
    ena = 1'b0; mode = 2'd2; step = 8'd3; hi = 8'd50;
    for (int i = 0; i < 5; i++) step_exp("hold", 100, 1, 0);
    rst = 1'b1; ena = 1'b1; mode = 2'd0; hi = 8'd255; step = 8'd10;
    step_exp("rst3", 0, 0, 0);
    rst = 1'b0;

    // Bounds reprogrammed under a ramp, then inverted bounds.
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("ramp50", int'(out), 10 * i);
    end
    hi = 8'd30;
    step_exp("clamp_hi", 30, 0, 0);
    lo = 8'd40;
    step_exp("lo_gt_hi_a", 40, 0, 0);
    step_exp("lo_gt_hi_b", 40, 0, 0);

    // Randomized phase; the negedge process compares every cycle.
    lo = 8'd0; hi = 8'd255;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        lo = 8'($urandom_range(0, 255));
        hi = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0 && lo > hi) begin
          hi = lo;
          lo = 8'($urandom_range(0, int'(hi)));
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) step = 8'($urandom_range(0, 5));
        else step = 8'($urandom_range(0, 255));
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
